// File: rtl/sd_clk_pkg.sv
// Shared types and default constants for the SD bus clock generator.
package sd_clk_pkg;

   typedef enum logic {MODE_SLOW = 1'b0, MODE_FAST = 1'b1} mode_t;
   typedef enum logic {ST_RUN = 1'b0, ST_PARKED = 1'b1} clk_state_t;

   localparam int          HALF_SLOW_DEF = 64;
   localparam int          HALF_FAST_DEF = 2;
   localparam logic [7:0]  INIT_END_DEF  = 8'h70;

   // Idle (0) and every post-initialisation state run at the fast rate.
   function automatic mode_t req_mode(input logic [7:0] state,
                                      input logic [7:0] init_end,
                                      input logic       force_fast);
      if (force_fast || state == 8'h00 || state >= init_end)
         return MODE_FAST;
      return MODE_SLOW;
   endfunction

endpackage

// File: rtl/sd_clk_gen.sv
// SD bus clock generator: slow/fast rates switched only at a falling edge, glitch-free park.
// Optional edge strobes are built when SDCLK_STROBE_EN is defined.
module sd_clk_gen
   import sd_clk_pkg::*;
#(
   parameter int         CNT_W     = 8,
   parameter int         HALF_SLOW = HALF_SLOW_DEF,
   parameter int         HALF_FAST = HALF_FAST_DEF,
   parameter logic [7:0] INIT_END  = INIT_END_DEF
) (
   input  logic       CLKin,
   input  logic       Reset,
   input  logic [7:0] State,
   input  logic       ForceFast,
   input  logic       Stop,
   output logic       CLKout,
   output logic       RiseStb,
   output logic       FallStb,
   output logic       FastActive,
   output logic       Stopped
);

   localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(HALF_SLOW - 1);
   localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(HALF_FAST - 1);

   clk_state_t       state_q, state_d;
   mode_t            mode_q, mode_d;
   mode_t            req;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tc_val;
   logic             clk_q, clk_d;
   logic             tc;

   always_ff @(posedge CLKin or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_RUN;
         mode_q  <= MODE_SLOW;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
      end
   end

   always_comb begin
      req     = req_mode(State, INIT_END, ForceFast);
      tc_val  = (mode_q == MODE_FAST) ? FAST_TC : SLOW_TC;
      tc      = (cnt_q == tc_val);
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      case (state_q)
         ST_RUN: begin
            if (tc) begin
               cnt_d = '0;
               if (clk_q) begin
                  // Rate may only change here so a high phase never gets cut short.
                  clk_d  = 1'b0;
                  mode_d = req;
               end else if (Stop) begin
                  state_d = ST_PARKED;
               end else begin
                  clk_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PARKED: begin
            mode_d = req;
            cnt_d  = '0;
            if (!Stop)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign CLKout     = clk_q;
   assign FastActive = (mode_q == MODE_FAST);
   assign Stopped    = (state_q == ST_PARKED);

`ifdef SDCLK_STROBE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      rise_d = clk_d & ~clk_q;
      fall_d = ~clk_d & clk_q;
   end

   always_ff @(posedge CLKin or negedge Reset) begin
      if (!Reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign RiseStb = rise_q;
   assign FallStb = fall_q;
`else
   assign RiseStb = 1'b0;
   assign FallStb = 1'b0;
`endif

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed self-checking bench for sd_clk_gen with default parameters.
module tb_sd_clk_gen;

   logic       CLKin = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] State = 8'h10;
   logic       ForceFast = 1'b0;
   logic       Stop = 1'b0;
   logic       CLKout, RiseStb, FallStb, FastActive, Stopped;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sd_clk_gen dut (
      .CLKin      (CLKin),
      .Reset      (Reset),
      .State      (State),
      .ForceFast  (ForceFast),
      .Stop       (Stop),
      .CLKout     (CLKout),
      .RiseStb    (RiseStb),
      .FallStb    (FallStb),
      .FastActive (FastActive),
      .Stopped    (Stopped)
   );

   always #5 CLKin = ~CLKin;
   always @(posedge CLKin) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   // Wait (sampling on falling CLKin edges) until CLKout reaches lvl; t = cycle stamp.
   task automatic wait_level(input logic lvl, input string tag, output int t);
      int n = 0;
      do begin
         @(negedge CLKin);
         n++;
      end while (CLKout !== lvl && n < 1000);
      if (CLKout !== lvl)
         check({tag, "_timeout"}, int'(CLKout), int'(lvl));
      t = cyc;
   endtask

   initial begin
      int t0, tr, tf, t1, hi, first_stop, nr, nf, mis;
      logic prev, er, ef;

      // Reset state
      repeat (3) @(negedge CLKin);
      check("rst_clkout", int'(CLKout), 0);
      check("rst_stopped", int'(Stopped), 0);
      check("rst_fast", int'(FastActive), 0);
      check("rst_rise", int'(RiseStb), 0);
      check("rst_fall", int'(FallStb), 0);

      // Slow start: first rise after 64 cycles, period 128
      Reset = 1'b1;
      t0 = cyc;
      wait_level(1'b1, "s1_rise", tr);
      check("s1_first_rise", tr - t0, 64);
      wait_level(1'b0, "s1_fall", tf);
      check("s1_high", tf - tr, 64);
      wait_level(1'b1, "s1_rise2", t1);
      check("s1_period", t1 - tr, 128);
      check("s1_fast", int'(FastActive), 0);

      // State goes fast mid high phase: high phase still slow
      repeat (10) @(negedge CLKin);
      State = 8'h80;
      check("s2_fast_before", int'(FastActive), 0);
      wait_level(1'b0, "s2_fall", tf);
      check("s2_high", tf - t1, 64);
      check("s2_fast_at_fall", int'(FastActive), 1);
      wait_level(1'b1, "s2_rise", tr);
      check("s2_low", tr - tf, 2);
      wait_level(1'b0, "s2_fall2", tf);
      check("s2_high_fast", tf - tr, 2);

      // Strobe window: 40 cycles starting right after a fall = 10 fast periods
      prev = CLKout;
      nr = 0; nf = 0; mis = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLKin);
         if (RiseStb) nr++;
         if (FallStb) nf++;
         er = CLKout & ~prev;
         ef = ~CLKout & prev;
         if (RiseStb !== er || FallStb !== ef) mis++;
         prev = CLKout;
      end
`ifdef SDCLK_STROBE_EN
      check("stb_rise_count", nr, 10);
      check("stb_fall_count", nf, 10);
      check("stb_misaligned", mis, 0);
`else
      check("stb_rise_tied", nr, 0);
      check("stb_fall_tied", nf, 0);
`endif

      // Stop asserted at the start of a fast high phase
      wait_level(1'b1, "s3_rise", tr);
      Stop = 1'b1;
      hi = 0;
      first_stop = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge CLKin);
         if (CLKout) hi++;
         if (Stopped && first_stop == 0) first_stop = i;
      end
      check("s3_high_samples", hi, 1);
      check("s3_park_delay", first_stop, 4);
      check("s3_parked_clk", int'(CLKout), 0);
      check("s3_stopped", int'(Stopped), 1);
      Stop = 1'b0;
      @(negedge CLKin);
      check("s3_unparked", int'(Stopped), 0);
      check("s3_clk_low", int'(CLKout), 0);
      t0 = cyc;
      wait_level(1'b1, "s3_restart", tr);
      check("s3_restart_delay", tr - t0, 2);
      check("s3_fast", int'(FastActive), 1);

      // Back to slow, then ForceFast with an init-range State
      State = 8'h10;
      wait_level(1'b0, "s6_fall", tf);
      check("s6_high_fast", tf - tr, 2);
      check("s6_slow_at_fall", int'(FastActive), 0);
      wait_level(1'b1, "s6_rise", tr);
      check("s6_low_slow", tr - tf, 64);
      State = 8'h05;
      ForceFast = 1'b1;
      wait_level(1'b0, "s6_fall2", tf);
      check("s6_high_slow", tf - tr, 64);
      check("s6_forcefast", int'(FastActive), 1);
      wait_level(1'b1, "s6_rise2", tr);
      check("s6_low_fast", tr - tf, 2);
      wait_level(1'b0, "s6_fall3", t1);
      check("s6_period_half", t1 - tr, 2);

      // Asynchronous reset in the middle of a high phase
      wait_level(1'b1, "s4_rise", tr);
      #2 Reset = 1'b0;
      #1;
      check("s4_clk_async", int'(CLKout), 0);
      check("s4_stopped_async", int'(Stopped), 0);
      check("s4_fast_async", int'(FastActive), 0);
      ForceFast = 1'b0;
      State = 8'h10;
      repeat (3) @(negedge CLKin);
      Reset = 1'b1;
      t0 = cyc;
      wait_level(1'b1, "s4_rise2", tr);
      check("s4_first_rise", tr - t0, 64);
      wait_level(1'b0, "s4_fall", tf);
      check("s4_high", tf - tr, 64);
      check("s4_fast", int'(FastActive), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
